// File: rtl/glb_iact_pingpong_if.sv
// Writer/reader handshake bundle for the ping-pong iact global buffer.
// master = DMA loader + spad feeder side, slave = the buffer.
interface glb_iact_pingpong_if #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10
);
  logic                     w_en;
  logic [ADDR_BITWIDTH-1:0] w_addr;
  logic [DATA_BITWIDTH-1:0] w_data;
  logic                     w_done;
  logic                     w_ready;
  logic                     read_req;
  logic [ADDR_BITWIDTH-1:0] r_addr;
  logic [DATA_BITWIDTH-1:0] r_data;
  logic                     r_valid;
  logic                     r_done;
  logic                     r_ready;

  modport master (
    output w_en, w_addr, w_data, w_done,
    output read_req, r_addr, r_done,
    input  w_ready, r_data, r_valid, r_ready
  );

  modport slave (
    input  w_en, w_addr, w_data, w_done,
    input  read_req, r_addr, r_done,
    output w_ready, r_data, r_valid, r_ready
  );
endinterface

// File: rtl/glb_iact_pingpong.sv
// Two-bank ping-pong iact GLB; writer fills one bank while reader drains the other.
// Define GLB_IACT_STATS_EN to add swap_count / stall_count.
module glb_iact_pingpong #(
  parameter int DATA_BITWIDTH  = 16,
  parameter int ADDR_BITWIDTH  = 10,
  parameter int COUNT_BITWIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  glb_iact_pingpong_if.slave bus,
  output logic err
`ifdef GLB_IACT_STATS_EN
  ,
  output logic [COUNT_BITWIDTH-1:0] swap_count,
  output logic [COUNT_BITWIDTH-1:0] stall_count
`endif
);
  localparam int DEPTH = 2 ** (ADDR_BITWIDTH + 1);

  logic [DATA_BITWIDTH-1:0] mem [DEPTH];
  logic [1:0] full, full_nxt;
  logic       wr_sel, wr_sel_nxt;
  logic       rd_sel, rd_sel_nxt;
  logic       w_rdy, r_rdy;
  logic       w_acc, wd_acc;
  logic       rq_acc, rd_acc;
  logic       viol;

  assign w_rdy  = !full[wr_sel];
  assign r_rdy  = full[rd_sel];
  assign w_acc  = bus.w_en && w_rdy;
  assign wd_acc = bus.w_done && w_rdy;
  assign rq_acc = bus.read_req && r_rdy;
  assign rd_acc = bus.r_done && r_rdy;

  assign viol = (bus.w_en && !w_rdy)
             || (bus.w_done && !w_rdy)
             || (bus.read_req && !r_rdy)
             || (bus.r_done && !r_rdy);

  assign bus.w_ready = w_rdy;
  assign bus.r_ready = r_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      full   <= full_nxt;
      wr_sel <= wr_sel_nxt;
      rd_sel <= rd_sel_nxt;
    end
  end

  // wr_sel==rd_sel makes w_rdy/r_rdy exclusive, so both updates never hit one bank
  always_comb begin
    full_nxt   = full;
    wr_sel_nxt = wr_sel;
    rd_sel_nxt = rd_sel;
    if (wd_acc) begin
      full_nxt[wr_sel] = 1'b1;
      wr_sel_nxt       = !wr_sel;
    end
    if (rd_acc) begin
      full_nxt[rd_sel] = 1'b0;
      rd_sel_nxt       = !rd_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc)
      mem[{wr_sel, bus.w_addr}] <= bus.w_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.r_valid <= 1'b0;
      bus.r_data  <= '0;
    end else begin
      bus.r_valid <= rq_acc;
      if (rq_acc)
        bus.r_data <= mem[{rd_sel, bus.r_addr}];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      err <= 1'b0;
    else if (viol)
      err <= 1'b1;
  end

`ifdef GLB_IACT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      swap_count  <= '0;
      stall_count <= '0;
    end else begin
      if (rd_acc && !(&swap_count))
        swap_count <= swap_count + 1'b1;
      if (bus.w_en && !w_rdy && !(&stall_count))
        stall_count <= stall_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_glb_iact_pingpong.sv
// Directed self-checking bench for glb_iact_pingpong.
// Counter checks are compiled in only with GLB_IACT_STATS_EN.
module tb_glb_iact_pingpong;
  localparam int DW = 16;
  localparam int AW = 10;
`ifdef GLB_IACT_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic clk = 1'b0;
  logic reset;
  logic err;
  int   tests = 0;
  int   fails = 0;

  glb_iact_pingpong_if #(
    .DATA_BITWIDTH(DW),
    .ADDR_BITWIDTH(AW)
  ) bus ();

`ifdef GLB_IACT_STATS_EN
  logic [CW-1:0] swap_count;
  logic [CW-1:0] stall_count;
`endif

  glb_iact_pingpong #(
    .DATA_BITWIDTH (DW),
    .ADDR_BITWIDTH (AW),
    .COUNT_BITWIDTH(CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave),
    .err  (err)
`ifdef GLB_IACT_STATS_EN
    ,
    .swap_count (swap_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wr(
    input logic [AW-1:0] a,
    input logic [DW-1:0] d
  );
    bus.w_en   = 1'b1;
    bus.w_addr = a;
    bus.w_data = d;
    tick();
    bus.w_en   = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    bus.read_req = 1'b1;
    bus.r_addr   = a;
    tick();
    bus.read_req = 1'b0;
  endtask

  task automatic wdone();
    bus.w_done = 1'b1;
    tick();
    bus.w_done = 1'b0;
  endtask

  task automatic rdone();
    bus.r_done = 1'b1;
    tick();
    bus.r_done = 1'b0;
  endtask

  task automatic chk_rd(
    input string         tag,
    input logic [AW-1:0] a,
    input logic [DW-1:0] d
  );
    rd(a);
    chk({tag, "_valid"}, 32'(bus.r_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.r_data), 32'(d));
  endtask

  initial begin
    reset        = 1'b1;
    bus.w_en     = 1'b0;
    bus.w_addr   = '0;
    bus.w_data   = '0;
    bus.w_done   = 1'b0;
    bus.read_req = 1'b0;
    bus.r_addr   = '0;
    bus.r_done   = 1'b0;
    do_reset();

    chk("rst_w_ready", 32'(bus.w_ready), 32'd1);
    chk("rst_r_ready", 32'(bus.r_ready), 32'd0);
    chk("rst_r_valid", 32'(bus.r_valid), 32'd0);
    chk("rst_r_data", 32'(bus.r_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    for (int i = 0; i < 4; i++)
      wr(AW'(i), DW'(16'h11 + i));
    chk("fill_r_ready", 32'(bus.r_ready), 32'd0);
    wdone();
    chk("b0_r_ready", 32'(bus.r_ready), 32'd1);
    chk("b1_w_ready", 32'(bus.w_ready), 32'd1);
    chk_rd("rd_a2", 10'd2, 16'h0013);
    chk_rd("rd_a3", 10'd3, 16'h0014);
    tick();
    chk("idle_valid", 32'(bus.r_valid), 32'd0);
    chk("idle_hold", 32'(bus.r_data), 32'h14);

    bus.w_en     = 1'b1;
    bus.w_addr   = 10'd5;
    bus.w_data   = 16'hBEEF;
    bus.read_req = 1'b1;
    bus.r_addr   = 10'd0;
    tick();
    bus.w_en     = 1'b0;
    bus.read_req = 1'b0;
    chk("ovl_valid", 32'(bus.r_valid), 32'd1);
    chk("ovl_data", 32'(bus.r_data), 32'h11);
    wr(10'd0, 16'h0055);
    bus.w_done   = 1'b1;
    bus.r_done   = 1'b1;
    bus.read_req = 1'b1;
    bus.r_addr   = 10'd1;
    tick();
    bus.w_done   = 1'b0;
    bus.r_done   = 1'b0;
    bus.read_req = 1'b0;
    chk("rel_data", 32'(bus.r_data), 32'h12);
    chk("swp_r_ready", 32'(bus.r_ready), 32'd1);
    chk("swp_w_ready", 32'(bus.w_ready), 32'd1);
    chk("swp_err", 32'(err), 32'd0);
    chk_rd("b1_a5", 10'd5, 16'hBEEF);
    chk_rd("b1_a0", 10'd0, 16'h0055);

    wr(10'd1, 16'h0022);
    wdone();
    chk("both_w_ready", 32'(bus.w_ready), 32'd0);
    chk("both_r_ready", 32'(bus.r_ready), 32'd1);
    wr(10'd0, 16'hDEAD);
    chk("drop_err", 32'(err), 32'd1);
    chk_rd("drop_b1_a0", 10'd0, 16'h0055);
    rdone();
    chk("free_w_ready", 32'(bus.w_ready), 32'd1);
    chk_rd("b0_a0", 10'd0, 16'h0011);
    chk_rd("b0_a1", 10'd1, 16'h0022);
    chk("sticky_err", 32'(err), 32'd1);

    reset        = 1'b1;
    bus.read_req = 1'b1;
    bus.r_addr   = 10'd0;
    tick();
    reset        = 1'b0;
    bus.read_req = 1'b0;
    chk("rstrd_valid", 32'(bus.r_valid), 32'd0);
    chk("rstrd_data", 32'(bus.r_data), 32'd0);
    chk("rstrd_r_ready", 32'(bus.r_ready), 32'd0);
    chk("rstrd_w_ready", 32'(bus.w_ready), 32'd1);
    chk("rstrd_err", 32'(err), 32'd0);
    rd(10'd0);
    chk("badrd_valid", 32'(bus.r_valid), 32'd0);
    chk("badrd_data", 32'(bus.r_data), 32'd0);
    chk("badrd_err", 32'(err), 32'd1);

    do_reset();
    rdone();
    chk("badrdone_err", 32'(err), 32'd1);
    chk("badrdone_rdy", 32'(bus.r_ready), 32'd0);

    do_reset();
    wdone();
    wdone();
    chk("full2_w_ready", 32'(bus.w_ready), 32'd0);
    chk("full2_err", 32'(err), 32'd0);
    wdone();
    chk("badwdone_err", 32'(err), 32'd1);
    chk("badwdone_rrdy", 32'(bus.r_ready), 32'd1);
    chk("badwdone_wrdy", 32'(bus.w_ready), 32'd0);

    do_reset();
    wr(10'd0, 16'h0001);
    wr(10'd1, 16'h0002);
    do_reset();
    chk("midfill_w_ready", 32'(bus.w_ready), 32'd1);
    chk("midfill_r_ready", 32'(bus.r_ready), 32'd0);
    chk("midfill_err", 32'(err), 32'd0);

`ifdef GLB_IACT_STATS_EN
    chk("st_rst_swap", 32'(swap_count), 32'd0);
    chk("st_rst_stall", 32'(stall_count), 32'd0);
    wdone();
    wdone();
    repeat (4) wr(10'd0, 16'h0);
    rdone();
    rdone();
    wdone();
    rdone();
    chk("st_swap3", 32'(swap_count), 32'd3);
    chk("st_stall4", 32'(stall_count), 32'd4);
    repeat (14) begin
      wdone();
      rdone();
    end
    chk("st_swap_sat", 32'(swap_count), 32'hF);
    wdone();
    wdone();
    repeat (14) wr(10'd0, 16'h0);
    chk("st_stall_sat", 32'(stall_count), 32'hF);
    do_reset();
    chk("st_clr_swap", 32'(swap_count), 32'd0);
    chk("st_clr_stall", 32'(stall_count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule
